// File: rtl/fpu_sched_pkg.sv
// ---------------------------------------------------------------------------
// fpu_sched_pkg
//   Shared types and sizing constants for the FPU operation scheduler.
//   - sched_state_t : scheduler FSM states
//   - sched_desc_t  : one queued operation (unit index + region bounds)
//   The PKG_* constants size the descriptor struct; the scheduler top
//   checks at elaboration that its own parameters fit these sizes.
// ---------------------------------------------------------------------------
package fpu_sched_pkg;

   localparam int PKG_NUM_UNITS   = 8;
   localparam int PKG_NUM_HANDLES = 4;
   localparam int PKG_ADDR_W      = 32;
   localparam int PKG_UNIT_W      = $clog2(PKG_NUM_UNITS);
   localparam int PKG_REGION_W    = PKG_NUM_HANDLES * PKG_ADDR_W;

   typedef enum logic [2:0] {
      IDLE,
      CONFIG,
      GO,
      RELEASE,
      ABORT
   } sched_state_t;

   // rbegin/rend hold every handle's bounds, handle 0 in the LSBs.
   typedef struct packed {
      logic [PKG_UNIT_W-1:0]   unit;
      logic [PKG_REGION_W-1:0] rbegin;
      logic [PKG_REGION_W-1:0] rend;
   } sched_desc_t;

endpackage

// File: rtl/sched_desc_fifo.sv
// ---------------------------------------------------------------------------
// sched_desc_fifo
//   Synchronous FIFO of sched_desc_t, DEPTH entries (power of two, >= 2).
//   Ports:
//     clk, rst    : clock, asynchronous active-high reset (empties FIFO)
//     push        : write push_data (ignored when full)
//     push_data   : descriptor to enqueue
//     pop         : drop the head entry (ignored when empty)
//     full, empty : occupancy flags
//     head        : oldest entry, valid while !empty
// ---------------------------------------------------------------------------
module sched_desc_fifo
   import fpu_sched_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        push,
   input  sched_desc_t push_data,
   input  logic        pop,
   output logic        full,
   output logic        empty,
   output sched_desc_t head
);

   localparam int PTR_W = $clog2(DEPTH);

   sched_desc_t      mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W:0]   count;
   logic             do_push;
   logic             do_pop;

   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign full    = (count == (PTR_W+1)'(DEPTH));
   assign empty   = (count == '0);
   assign head    = mem[rd_ptr];

   // Pointers wrap naturally because DEPTH is a power of two.
   // NOTE: sequential state uses non-blocking (<=) so every flop samples
   // the pre-edge values, independent of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (PTR_W+1)'(1);
            2'b01:   count <= count - (PTR_W+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // NOTE: the storage array has no reset; entries are only read after
   // being written, and leaving it unreset lets it map to plain RAM/flops.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/fpu_op_scheduler.sv
// ---------------------------------------------------------------------------
// fpu_op_scheduler
//   Queues operation descriptors and runs one go/done handshake per
//   descriptor on the selected FPU unit, after driving that descriptor's
//   region bounds onto the shared mem-handle inputs.
//   Ports:
//     clk, rst                  : clock, asynchronous active-high reset
//     desc_valid/desc_ready     : descriptor push handshake
//     desc_unit/begin/end       : descriptor fields (handle 0 in the LSBs)
//     region_begin/region_end   : bounds held from CONFIG until next CONFIG
//     unit_go/unit_done         : one-hot go, per-unit done
//     busy                      : FSM not IDLE or FIFO non-empty
//     op_count                  : completed operations (wraps)
//     bad_unit                  : sticky, descriptor named a missing unit
//     timeout                   : sticky watchdog flag
//   Optional: define FPU_SCHED_WATCHDOG_EN to abort a handshake that stays
//   in GO/RELEASE for TIMEOUT_CYCLES cycles; otherwise timeout is 0.
// ---------------------------------------------------------------------------
module fpu_op_scheduler
   import fpu_sched_pkg::*;
#(
   parameter int NUM_UNITS      = 8,
   parameter int NUM_HANDLES    = 4,
   parameter int ADDR_W         = 32,
   parameter int FIFO_DEPTH     = 4,
   parameter int TIMEOUT_CYCLES = 65535
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          desc_valid,
   output logic                          desc_ready,
   input  logic [$clog2(NUM_UNITS)-1:0]  desc_unit,
   input  logic [NUM_HANDLES*ADDR_W-1:0] desc_begin,
   input  logic [NUM_HANDLES*ADDR_W-1:0] desc_end,
   output logic [NUM_HANDLES*ADDR_W-1:0] region_begin,
   output logic [NUM_HANDLES*ADDR_W-1:0] region_end,
   output logic [NUM_UNITS-1:0]          unit_go,
   input  logic [NUM_UNITS-1:0]          unit_done,
   output logic                          busy,
   output logic [15:0]                   op_count,
   output logic                          bad_unit,
   output logic                          timeout
);

   localparam int U_W = $clog2(NUM_UNITS);

   if (NUM_HANDLES * ADDR_W != PKG_REGION_W || U_W > PKG_UNIT_W ||
       FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
       TIMEOUT_CYCLES < 1) begin : g_cfg_check
      $error("fpu_op_scheduler: parameters do not fit fpu_sched_pkg sizing");
   end

   sched_state_t   state;
   sched_state_t   state_nx;
   sched_desc_t    push_data;
   sched_desc_t    head;
   logic [U_W-1:0] cur_unit;
   logic           fifo_full;
   logic           fifo_empty;
   logic           unit_ok;
   logic           sel_done;
   logic           wd_hit;
   logic           op_done;

   assign push_data = '{unit: PKG_UNIT_W'(desc_unit), rbegin: desc_begin, rend: desc_end};

   sched_desc_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (desc_valid),
      .push_data (push_data),
      .pop       (state == CONFIG),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .head      (head)
   );

   assign desc_ready = ~fifo_full;
   assign busy       = (state != IDLE) | ~fifo_empty;
   assign unit_ok    = int'(head.unit) < NUM_UNITS;
   // Only the selected unit's done matters; other bits are ignored.
   assign sel_done   = unit_done[cur_unit];
   assign op_done    = (state == RELEASE) && !sel_done && !wd_hit;

   // NOTE: every signal written here is assigned a default first, so no
   // path through the block can leave it unassigned and infer a latch.
   always_comb begin
      state_nx = state;
      unit_go  = '0;
      case (state)
         IDLE:    if (!fifo_empty) state_nx = CONFIG;
         CONFIG:  state_nx = unit_ok ? GO : IDLE;
         GO: begin
            unit_go[cur_unit] = 1'b1;
            if (sel_done) state_nx = RELEASE;
         end
         RELEASE: if (!sel_done) state_nx = fifo_empty ? IDLE : CONFIG;
         ABORT:   state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
      if (wd_hit) state_nx = ABORT;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         cur_unit     <= '0;
         region_begin <= '0;
         region_end   <= '0;
         op_count     <= '0;
         bad_unit     <= 1'b0;
      end else begin
         state <= state_nx;
         if (state == CONFIG) begin
            if (unit_ok) begin
               cur_unit     <= head.unit[U_W-1:0];
               region_begin <= head.rbegin;
               region_end   <= head.rend;
            end else begin
               bad_unit <= 1'b1;
            end
         end
         if (op_done) op_count <= op_count + 16'd1;
      end
   end

`ifdef FPU_SCHED_WATCHDOG_EN
   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [WD_W-1:0] wd_cnt;

   // wd_cnt counts cycles already spent in GO/RELEASE; the cycle that would
   // make it TIMEOUT_CYCLES is the last one before ABORT.
   assign wd_hit = ((state == GO) || (state == RELEASE)) &&
                   (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wd_cnt  <= '0;
         timeout <= 1'b0;
      end else begin
         // GO is only ever entered from CONFIG, so clearing here clears on entry.
         if (state == CONFIG) wd_cnt <= '0;
         else if ((state == GO) || (state == RELEASE)) wd_cnt <= wd_cnt + WD_W'(1);
         if (wd_hit) timeout <= 1'b1;
      end
   end
`else
   assign wd_hit  = 1'b0;
   assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_fpu_op_scheduler.sv
// ---------------------------------------------------------------------------
// tb_fpu_op_scheduler
//   Self-checking bench for fpu_op_scheduler (NUM_UNITS=6, TIMEOUT_CYCLES=16).
//   Directed table vectors, multi-cycle corner sequences, and a randomized
//   producer/responder phase checked against an in-order descriptor queue.
// ---------------------------------------------------------------------------
module tb_fpu_op_scheduler;

   localparam int NU = 6;
   localparam int RW = 128;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          desc_valid = 1'b0;
   logic          desc_ready;
   logic [2:0]    desc_unit = '0;
   logic [RW-1:0] desc_begin = '0;
   logic [RW-1:0] desc_end = '0;
   logic [RW-1:0] region_begin;
   logic [RW-1:0] region_end;
   logic [NU-1:0] unit_go;
   logic [NU-1:0] unit_done = '0;
   logic          busy;
   logic [15:0]   op_count;
   logic          bad_unit;
   logic          timeout;

   int n_chk  = 0;
   int n_pass = 0;
   int oh_viol = 0;

   typedef struct {
      logic [2:0]    unit;
      logic [RW-1:0] b;
      logic [RW-1:0] e;
   } op_t;

   typedef struct {
      logic [2:0]    unit;
      logic [RW-1:0] b;
      logic [RW-1:0] e;
      int            delay;
      logic [NU-1:0] go_exp;
   } vec_t;

   op_t  model_q[$];
   vec_t vecs[4];

   fpu_op_scheduler #(
      .NUM_UNITS(NU), .NUM_HANDLES(4), .ADDR_W(32), .FIFO_DEPTH(4), .TIMEOUT_CYCLES(16)
   ) dut (
      .clk(clk), .rst(rst),
      .desc_valid(desc_valid), .desc_ready(desc_ready), .desc_unit(desc_unit),
      .desc_begin(desc_begin), .desc_end(desc_end),
      .region_begin(region_begin), .region_end(region_end),
      .unit_go(unit_go), .unit_done(unit_done),
      .busy(busy), .op_count(op_count), .bad_unit(bad_unit), .timeout(timeout)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if ($countones(unit_go) > 1) oh_viol++;

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish, got %0d/%0d", n_pass, n_chk);
      $fatal(1);
   end

   task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   function automatic logic [NU-1:0] oh(input logic [2:0] u);
      logic [NU-1:0] one = 1;
      return one << u;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      desc_valid = 1'b0;
      unit_done  = '0;
      #2 rst = 1'b1;
      #2 rst = 1'b0;
      tick();
   endtask

   // Offers one descriptor and returns just after the edge that accepted it.
   task automatic push(input logic [2:0] u, input logic [RW-1:0] b, input logic [RW-1:0] e);
      int n = 0;
      desc_unit = u; desc_begin = b; desc_end = e; desc_valid = 1'b1;
      while (!desc_ready && n < 200) begin tick(); n++; end
      tick();
      desc_valid = 1'b0;
   endtask

   // Behaves as unit u: waits for go, checks it and the regions, raises done
   // after 'delay' cycles, lowers it one cycle after go falls.
   task automatic serve(input logic [2:0] u, input logic [RW-1:0] b, input logic [RW-1:0] e,
                        input int delay);
      int n = 0;
      while (unit_go == '0 && n < 100) begin tick(); n++; end
      check("serve_go", unit_go, oh(u));
      check("serve_region_begin", region_begin, b);
      check("serve_region_end", region_end, e);
      repeat (delay) tick();
      check("serve_go_held", unit_go, oh(u));
      unit_done[u] = 1'b1;
      n = 0;
      while (unit_go != '0 && n < 100) begin tick(); n++; end
      tick();
      unit_done[u] = 1'b0;
      tick();
   endtask

   initial begin
      logic [RW-1:0] rb [5];
      logic [RW-1:0] re [5];
      logic [15:0]   cnt0;
      int            n;

      vecs[0] = '{3'd2, 128'h10, 128'h14, 5, 6'b000100};
      vecs[1] = '{3'd5, 128'h0000_0040_0000_0030_0000_0020_0000_0010,
                        128'h0000_0044_0000_0034_0000_0024_0000_0014, 0, 6'b100000};
      vecs[2] = '{3'd0, {4{32'hFFFF_FFFF}}, 128'h0, 2, 6'b000001};
      vecs[3] = '{3'd3, 128'hDEAD_BEEF_0123_4567_89AB_CDEF_0F0F_F0F0,
                        128'h1111_2222_3333_4444_5555_6666_7777_8888, 1, 6'b001000};

      // ---- reset state
      tick(); tick();
      check("rst_go", unit_go, '0);
      check("rst_region_begin", region_begin, '0);
      check("rst_region_end", region_end, '0);
      check("rst_op_count", op_count, 16'd0);
      check("rst_bad_unit", bad_unit, 1'b0);
      check("rst_timeout", timeout, 1'b0);
      check("rst_desc_ready", desc_ready, 1'b1);
      check("rst_busy", busy, 1'b0);
      rst = 1'b0;
      tick();

      // ---- table-driven single ops: go two edges after accept, then handshake
      for (int i = 0; i < 4; i++) begin
         push(vecs[i].unit, vecs[i].b, vecs[i].e);
         check("vec_go_after_e0", unit_go, '0);
         check("vec_busy", busy, 1'b1);
         tick();
         check("vec_go_after_e1", unit_go, '0);
         tick();
         check("vec_go_after_e2", unit_go, vecs[i].go_exp);
         check("vec_region_begin", region_begin, vecs[i].b);
         check("vec_region_end", region_end, vecs[i].e);
         repeat (vecs[i].delay) tick();
         check("vec_go_hold", unit_go, vecs[i].go_exp);
         unit_done[vecs[i].unit] = 1'b1;
         tick();
         check("vec_go_fall", unit_go, '0);
         tick();
         check("vec_count_before_done_fall", op_count, 16'(i));
         unit_done[vecs[i].unit] = 1'b0;
         tick();
         check("vec_op_count", op_count, 16'(i + 1));
         check("vec_idle", busy, 1'b0);
         check("vec_regions_held", region_begin, vecs[i].b);
      end

      // ---- FIFO full while unit 0 stalls
      do_reset();
      for (int i = 0; i < 5; i++) begin
         rb[i] = {32'(i), 32'hA000_0000, 32'h0, 32'h100 * (i + 1)};
         re[i] = {32'(i), 32'hB000_0000, 32'h0, 32'h100 * (i + 1) + 32'h80};
         push(3'(i), rb[i], re[i]);
      end
      check("full_desc_ready", desc_ready, 1'b0);
      tick(); tick();
      check("full_stalled_go", unit_go, oh(3'd0));
      check("full_still_full", desc_ready, 1'b0);
      serve(3'd0, rb[0], re[0], 0);
      check("full_ready_before_pop", desc_ready, 1'b0);
      tick();
      check("full_ready_after_pop", desc_ready, 1'b1);
      for (int i = 1; i < 5; i++) serve(3'(i), rb[i], re[i], i - 1);
      check("full_op_count", op_count, 16'd5);
      check("full_idle", busy, 1'b0);

      // ---- invalid unit followed by a valid one
      do_reset();
      push(3'd7, 128'h7777, 128'h7778);
      push(3'd1, 128'h1234_0000, 128'h1234_0100);
      tick();
      check("bad_unit_set", bad_unit, 1'b1);
      check("bad_regions_unchanged", region_begin, '0);
      check("bad_no_go", unit_go, '0);
      serve(3'd1, 128'h1234_0000, 128'h1234_0100, 1);
      check("bad_op_count", op_count, 16'd1);
      check("bad_sticky", bad_unit, 1'b1);
      check("bad_final_region_end", region_end, 128'h1234_0100);

      // ---- reset while unit 3 is in go
      push(3'd3, 128'h3000, 128'h3100);
      push(3'd2, 128'h2000, 128'h2100);
      n = 0;
      while (unit_go == '0 && n < 50) begin tick(); n++; end
      check("rstmid_go", unit_go, oh(3'd3));
      #3 rst = 1'b1;
      #1;
      check("rstmid_go_async", unit_go, '0);
      check("rstmid_desc_ready", desc_ready, 1'b1);
      check("rstmid_op_count", op_count, 16'd0);
      check("rstmid_busy", busy, 1'b0);
      check("rstmid_bad_cleared", bad_unit, 1'b0);
      #1 rst = 1'b0;
      tick(); tick(); tick();
      check("rstmid_no_issue", unit_go, '0);

      // ---- foreign done held high on unit 5 during an op on unit 4
      do_reset();
      unit_done[5] = 1'b1;
      push(3'd4, 128'h4400, 128'h4480);
      serve(3'd4, 128'h4400, 128'h4480, 6);
      check("foreign_op_count", op_count, 16'd1);
      unit_done[5] = 1'b0;

      // ---- stale done: already high when go rises counts as completion
      unit_done[2] = 1'b1;
      push(3'd2, 128'h2200, 128'h2280);
      tick(); tick();
      check("stale_go", unit_go, oh(3'd2));
      tick();
      check("stale_go_fall", unit_go, '0);
      unit_done[2] = 1'b0;
      tick();
      check("stale_op_count", op_count, 16'd2);

`ifdef FPU_SCHED_WATCHDOG_EN
      // ---- watchdog: unit 1 never answers
      do_reset();
      push(3'd1, 128'h1100, 128'h1180);
      push(3'd2, 128'h2500, 128'h2580);
      n = 0;
      while (unit_go == '0 && n < 50) begin tick(); n++; end
      check("wd_go", unit_go, oh(3'd1));
      n = 0;
      while (unit_go != '0 && n < 40) begin tick(); n++; end
      check("wd_go_cycles", 128'(n), 128'd16);
      check("wd_timeout", timeout, 1'b1);
      check("wd_op_count", op_count, 16'd0);
      serve(3'd2, 128'h2500, 128'h2580, 1);
      check("wd_next_op_count", op_count, 16'd1);
      check("wd_timeout_sticky", timeout, 1'b1);
`endif

      // ---- randomized: producer and responder against an in-order queue
      do_reset();
      cnt0 = op_count;
      fork
         begin : producer
            for (int k = 0; k < 24; k++) begin
               op_t d;
               repeat ($urandom_range(0, 3)) tick();
               d.unit = 3'($urandom_range(0, NU - 1));
               d.b = {$urandom(), $urandom(), $urandom(), $urandom()};
               d.e = {$urandom(), $urandom(), $urandom(), $urandom()};
               push(d.unit, d.b, d.e);
               model_q.push_back(d);
            end
         end
         begin : responder
            for (int k = 0; k < 24; k++) begin
               op_t exp_op;
               int  w = 0;
               while (unit_go == '0 && w < 300) begin tick(); w++; end
               exp_op = '{3'd0, '0, '0};
               if (model_q.size() > 0) exp_op = model_q.pop_front();
               check("rand_go", unit_go, oh(exp_op.unit));
               check("rand_region_begin", region_begin, exp_op.b);
               check("rand_region_end", region_end, exp_op.e);
               repeat ($urandom_range(0, 3)) tick();
               unit_done[exp_op.unit] = 1'b1;
               w = 0;
               while (unit_go != '0 && w < 100) begin tick(); w++; end
               repeat ($urandom_range(0, 2)) tick();
               unit_done[exp_op.unit] = 1'b0;
               tick();
            end
         end
      join
      n = 0;
      while (busy && n < 100) begin tick(); n++; end
      check("rand_op_count", op_count, cnt0 + 16'd24);
      check("rand_queue_drained", 128'(model_q.size()), 128'd0);
      check("rand_bad_unit", bad_unit, 1'b0);

      check("go_onehot_violations", 128'(oh_viol), 128'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/fpu_op_scheduler.md
Name: fpu_op_scheduler

Overview:
- Sequences FPU operation units (linear bias gradient, etc.) that use the go/done handshake.
- Accepts operation descriptors (unit select plus per-handle memory region bounds) into a small FIFO.
- For each descriptor, drives the region bounds to the shared mem_handle region inputs, then runs one go/done cycle on the selected unit.
- Sits between the worker command decoder and the FPU unit array.

Parameters:
NUM_UNITS, 8, number of FPU op units; width of the go/done vectors
NUM_HANDLES, 4, mem handles per unit (a, b, c, d)
ADDR_W, 32, region address width
FIFO_DEPTH, 4, descriptor FIFO entries; power of two, at least 2
TIMEOUT_CYCLES, 65535, watchdog limit; used only with FPU_SCHED_WATCHDOG_EN

Ports:
clk  in  1  clock; all state changes on the rising edge
rst  in  1  asynchronous, active-high reset
desc_valid  in  1  descriptor offered
desc_ready  out  1  FIFO can accept a descriptor
desc_unit  in  $clog2(NUM_UNITS)  target unit index
desc_begin  in  NUM_HANDLES*ADDR_W  region_begin per handle; handle 0 in the LSBs
desc_end  in  NUM_HANDLES*ADDR_W  region_end per handle
region_begin  out  NUM_HANDLES*ADDR_W  region_begin to the shared mem handles
region_end  out  NUM_HANDLES*ADDR_W  region_end to the shared mem handles
unit_go  out  NUM_UNITS  one-hot go
unit_done  in  NUM_UNITS  done from each unit
busy  out  1  high in any state other than IDLE, or when the FIFO is non-empty
op_count  out  16  completed operations; wraps from 0xFFFF to 0
bad_unit  out  1  sticky; set when a descriptor has desc_unit >= NUM_UNITS
timeout  out  1  sticky watchdog flag

Behaviour:
- Reset (async, immediate) sets:
  - unit_go=0, region_begin/region_end=0, op_count=0, bad_unit=0, timeout=0
  - FIFO empty, so desc_ready=1
  - state IDLE
- A reset during an operation drops go at once. Units return to their own WAIT state when go falls.
- Descriptor FIFO:
  - desc_ready = ~full (combinational on occupancy).
  - A push happens on a rising edge with desc_valid & desc_ready.
  - Push and pop in the same cycle are legal when non-empty; occupancy is unchanged.
  - No bypass: a descriptor always passes through the FIFO.
  - Pointers wrap modulo FIFO_DEPTH.
- State machine:
  - IDLE: FIFO non-empty goes to CONFIG; otherwise stay.
  - CONFIG: pop the head and latch region_begin/region_end from it.
    - Valid unit: go to GO.
    - Invalid unit: set bad_unit, leave regions unchanged, go to IDLE; op_count is not incremented.
  - GO: unit_go[u]=1, all other bits 0. When unit_done[u]=1, go to RELEASE; go falls on entry to RELEASE.
  - RELEASE: unit_go=0. When unit_done[u]=0, increment op_count.
    - Next state is CONFIG if the FIFO is non-empty, otherwise IDLE.
- Region outputs:
  - Regions are stable from the CONFIG edge until the next CONFIG; they are held through GO, RELEASE and IDLE.
  - A unit therefore samples valid region_begin on its first LOAD cycle.
- Latency:
  - A descriptor accepted at edge E into an empty FIFO in IDLE gives CONFIG after E+1 and unit_go high after E+2.
  - Back-to-back operations: go falls, then rises again two cycles after done falls (the RELEASE to CONFIG to GO path).
- unit_done bits other than the selected unit's are ignored in every state.
- unit_go is at most one-hot at all times.
- A done already high on entry to GO (a stale handshake) is treated as completion.

Optional Feature:
- Macro: FPU_SCHED_WATCHDOG_EN.
- Defined:
  - A cycle counter clears on entry to GO and counts in GO and RELEASE.
  - When the count reaches TIMEOUT_CYCLES, enter ABORT: unit_go=0, timeout set (sticky), op_count unchanged.
  - ABORT goes to IDLE on the next cycle without waiting for done to fall.
- Undefined: no counter, no ABORT state, timeout tied to 0, and GO/RELEASE wait indefinitely.

Decomposition:
- Package fpu_sched_pkg holds:
  - state enum {IDLE, CONFIG, GO, RELEASE, ABORT}
  - packed struct sched_desc_t {unit, begin, end}
  - localparam UNIT_W = $clog2(NUM_UNITS) default
- One sub-module: sched_desc_fifo, a parameterised synchronous FIFO of sched_desc_t with push, pop, full, empty and head.

Test Plan:
- Single op: push unit=2, a.begin=0x10, a.end=0x14 at edge 0. Then:
  - unit_go=0b100 after edge 2, with region_begin[0]=0x10.
  - Model holds done 5 cycles after go; done falls 1 cycle after go falls; op_count goes 0 to 1.
- FIFO full: push 5 descriptors while unit 0 stalls with done=0. Then:
  - desc_ready=0 after the FIFO holds 4.
  - Completing one op re-raises desc_ready.
  - All 5 ops execute in order and op_count=5.
- Invalid unit (NUM_UNITS=6): push unit=7, then unit=1. Then:
  - bad_unit=1, no go bit ever rises for the first descriptor, unit_go=0b10 next.
  - op_count=1; regions reflect the unit=1 descriptor only.
- Reset mid-op: assert rst while unit_go[3]=1. Then:
  - go=0 in the same cycle (async); FIFO empty, desc_ready=1, op_count=0.
- Stale/foreign done: unit_done[5]=1 held throughout an op on unit 4. No effect; completion occurs only on done[4].
- Watchdog (with FPU_SCHED_WATCHDOG_EN, TIMEOUT_CYCLES=16): unit never raises done. Then:
  - go drops after 16 cycles in GO; timeout=1, op_count=0.
  - The next queued descriptor issues normally.
